lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Pipeline-side initiator for the data-memory VALID/READY port: takes one load/store from the MEM stage,
//  builds byte mask and lane-replicated write data, drives VALID until READY, then aligns and extends the load data.
//  Stalls the pipeline while a transfer is outstanding. Flags misaligned/illegal accesses and responder timeouts.
// PARAMETERS
//  ADDR_W       18   byte-address width driven to memory (o_ADDR)
//  TIMEOUT_CYC  1024 max cycles VALID may wait for READY; 0 = no timeout
// PORTS
//  i_clk     in   1   clock
//  i_rst_n   in   1   reset: synchronous, active-low
//  i_req     in   1   access request from pipeline; sampled only in IDLE
//  i_wren    in   1   1 = store, 0 = load
//  i_funct3  in   3   RV32I funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//  i_addr    in   32  byte address (bits above ADDR_W ignored)
//  i_wdata   in   32  store data (rs2), right-justified
//  o_busy    out  1   stall: high in every state except IDLE
//  o_done    out  1   one-cycle pulse: transfer complete
//  o_rdata   out  32  extended load data; held until next load completes
//  o_err     out  1   one-cycle pulse: misaligned, illegal funct3, or timeout
//  o_ADDR    out  ADDR_W  byte address to memory, unmodified i_addr[ADDR_W-1:0]
//  o_WDATA   out  32  lane-replicated store data
//  o_BMASK   out  4   byte-lane enables (driven for loads and stores)
//  o_WREN    out  1   1 = write
//  o_VALID   out  1   request valid
//  i_READY   in   1   responder ack; one-cycle pulse
//  i_RDATA   in   32  read word; valid in the READY cycle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transfer aborts: VALID drops next edge, no done/err.
//  FSM IDLE/REQ/DONE/ERR:
//   IDLE: i_req & legal & aligned -> register addr/mask/wdata/wren/funct3, VALID=1 next cycle, -> REQ.
//         i_req & (misaligned | illegal funct3) -> ERR; no VALID issued.
//   REQ : VALID, ADDR, WDATA, BMASK, WREN held stable. i_READY=1 -> capture i_RDATA (loads), VALID=0 next cycle, -> DONE.
//         counter==TIMEOUT_CYC-1 without READY (TIMEOUT_CYC!=0) -> VALID=0, -> ERR.
//   DONE: o_done=1 one cycle, o_rdata updated (loads only), -> IDLE.
//   ERR : o_err=1 one cycle, o_rdata unchanged, -> IDLE.
//  VALID always deasserts for >=1 cycle between transfers (responder detects requests on VALID rise).
//  i_READY while not in REQ: ignored. READY and timeout in same cycle: READY wins.
//  Latency: i_req cycle T0 -> VALID T1; READY at Tn (n>=1) -> o_done Tn+1; min 2 cycles, 3-cycle issue rate.
//  Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0. Illegal funct3: load 3,6,7; store >=3.
//  Mask: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
//  WDATA: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  Load: byte/half selected from i_RDATA lane addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  Counter: counts REQ cycles, clears on entry to REQ; width clog2(TIMEOUT_CYC)+1.
// TESTING
//  SW addr 0x100 data 0xDEADBEEF, READY at T1 -> BMASK 1111, WDATA DEADBEEF, WREN 1, o_done T2, busy T1-T2.
//  LB addr 0x103, i_RDATA 0x80FF_0000 after 9 cycles -> BMASK 1000, o_rdata 0xFFFFFF80, done 1 cycle after READY.
//  LHU addr 0x102, i_RDATA 0x8001_1234 -> o_rdata 0x00008001; SH 0xABCD @0x102 -> WDATA ABCDABCD, BMASK 1100.
//  LW addr 0x101 / funct3=3 load -> o_err pulse T1, VALID never rises, o_rdata unchanged, busy 1 cycle.
//  TIMEOUT_CYC=8, READY held 0 -> VALID high 8 cycles, then o_err pulse; later stray READY ignored.
//  Back-to-back SB/LB same addr with i_req held -> VALID low >=1 cycle between; load returns stored byte.

Source files
------------

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for the data-memory
// VALID/READY port. Builds byte mask and replicated store data, holds the
// request stable until READY, then extends load data and pulses done.
// Misaligned or illegal accesses and responder timeouts pulse err instead.
//
// state | meaning
// IDLE  | waiting for a pipeline request; pipeline not stalled
// REQ   | VALID asserted, waiting for READY or timeout
// DONE  | one-cycle completion pulse, load data visible
// ERR   | one-cycle error pulse (misaligned, illegal funct3, timeout)
module lsu_mem_master #(
    parameter int ADDR_W      = 18,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_wren,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_ADDR,
    output logic [31:0]       o_WDATA,
    output logic [3:0]        o_BMASK,
    output logic              o_WREN,
    output logic              o_VALID,
    input  logic              i_READY,
    input  logic [31:0]       i_RDATA
);
    localparam int CNT_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;
    logic             illegal, misaligned, timeout_hit;
    logic [3:0]       mask_nx;
    logic [31:0]      wdata_nx, rdata_nx;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic             unused_addr;

    // Upper address bits beyond ADDR_W are intentionally dropped.
    assign unused_addr = ^i_addr;

    // Request decode: legality, alignment, byte lanes and replicated store data.
    always_comb begin
        illegal    = (i_funct3[1:0] == 2'b11) | (i_wren ? i_funct3[2] : (i_funct3 == 3'd6));
        misaligned = 1'b0;
        mask_nx    = 4'b1111;
        wdata_nx   = i_wdata;
        case (i_funct3[1:0])
            2'd0: begin
                mask_nx  = 4'b0001 << i_addr[1:0];
                wdata_nx = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = i_addr[0];
                mask_nx    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_nx   = {2{i_wdata[15:0]}};
            end
            2'd2: misaligned = (i_addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    // Load data: pick the addressed lane from the read word and extend it.
    always_comb begin
        rd_byte = i_RDATA[{lane_q, 3'b000} +: 8];
        rd_half = i_RDATA[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'd0:    rdata_nx = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    rdata_nx = {{16{rd_half[15]}}, rd_half};
            3'd4:    rdata_nx = {24'd0, rd_byte};
            3'd5:    rdata_nx = {16'd0, rd_half};
            default: rdata_nx = i_RDATA;
        endcase
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nx    = state;
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST));
        o_busy      = (state != S_IDLE);
        o_done      = (state == S_DONE);
        o_err       = (state == S_ERR);
        case (state)
            S_IDLE: if (i_req) state_nx = (illegal | misaligned) ? S_ERR : S_REQ;
            S_REQ: begin
                if (i_READY)          state_nx = S_DONE;
                else if (timeout_hit) state_nx = S_ERR;
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register and REQ-cycle counter (held at zero outside REQ).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_REQ) ? cnt + CNT_W'(1) : '0;
        end
    end

    // Memory-side request registers and load result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ADDR  <= '0;
            o_WDATA <= '0;
            o_BMASK <= '0;
            o_WREN  <= 1'b0;
            o_VALID <= 1'b0;
            o_rdata <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_REQ) begin
                o_ADDR  <= i_addr[ADDR_W-1:0];
                o_WDATA <= wdata_nx;
                o_BMASK <= mask_nx;
                o_WREN  <= i_wren;
                o_VALID <= 1'b1;
                f3_q    <= i_funct3;
                lane_q  <= i_addr[1:0];
            end else if (state == S_REQ && state_nx != S_REQ) begin
                o_VALID <= 1'b0;
            end
            if (state == S_REQ && i_READY && !o_WREN)
                o_rdata <= rdata_nx;
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed load/store sequences against a small word
// memory, with a second short-timeout instance for the timeout path.
module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        rst_n, req, wren, ready, req_to, ready_to;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, err, mem_wren, valid;
    logic [31:0] rdata, mem_wdata;
    logic [17:0] mem_addr;
    logic [3:0]  bmask;
    logic        busy_to, done_to, err_to, wren_to, valid_to;
    logic [31:0] rdata_to, wdata_to;
    logic [17:0] addr_to;
    logic [3:0]  bmask_to;
    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_master u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_rdata(rdata),
        .o_err(err), .o_ADDR(mem_addr), .o_WDATA(mem_wdata), .o_BMASK(bmask),
        .o_WREN(mem_wren), .o_VALID(valid), .i_READY(ready), .i_RDATA(mem_rdata)
    );

    lsu_mem_master #(.ADDR_W(18), .TIMEOUT_CYC(8)) u_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_to), .i_wren(wren), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata), .o_busy(busy_to), .o_done(done_to), .o_rdata(rdata_to),
        .o_err(err_to), .o_ADDR(addr_to), .o_WDATA(wdata_to), .o_BMASK(bmask_to),
        .o_WREN(wren_to), .o_VALID(valid_to), .i_READY(ready_to), .i_RDATA(32'h0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req    = 1'b1;
        wren   = wr;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
    endtask

    // Called at the negedge where the request was driven; returns at the done negedge.
    task automatic xfer(input string tag, input bit drop_req, input int lat,
                        input logic [3:0] e_mask, input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        logic [7:0] idx;
        @(negedge clk);
        if (drop_req) req = 1'b0;
        check_eq({tag, ":valid_t1"}, 32'(valid), 1);
        check_eq({tag, ":busy_t1"}, 32'(busy), 1);
        check_eq({tag, ":bmask"}, 32'(bmask), 32'(e_mask));
        check_eq({tag, ":wren"}, 32'(mem_wren), 32'(wren));
        check_eq({tag, ":addr"}, 32'(mem_addr), 32'(addr[17:0]));
        if (wren) check_eq({tag, ":wdata"}, mem_wdata, e_wdata);
        for (int i = 0; i < lat; i++) @(negedge clk);
        check_eq({tag, ":valid_wait"}, 32'(valid), 1);
        check_eq({tag, ":done_early"}, 32'(done), 0);
        idx   = mem_addr[9:2];
        ready = 1'b1;
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (bmask[b]) mem[idx][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end else begin
            mem_rdata = mem[idx];
        end
        @(negedge clk);
        ready     = 1'b0;
        mem_rdata = 32'h5555_5555;
        check_eq({tag, ":done"}, 32'(done), 1);
        check_eq({tag, ":valid_drop"}, 32'(valid), 0);
        check_eq({tag, ":busy_done"}, 32'(busy), 1);
        if (!wren) check_eq({tag, ":rdata"}, rdata, e_rdata);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        check_eq({tag, ":idle_done"}, 32'(done), 0);
        check_eq({tag, ":idle_busy"}, 32'(busy), 0);
        check_eq({tag, ":idle_valid"}, 32'(valid), 0);
    endtask

    // Called at the negedge where a bad request was driven.
    task automatic err_case(input string tag, input logic [31:0] e_rdata);
        @(negedge clk);
        req = 1'b0;
        check_eq({tag, ":err"}, 32'(err), 1);
        check_eq({tag, ":valid"}, 32'(valid), 0);
        check_eq({tag, ":busy"}, 32'(busy), 1);
        check_eq({tag, ":done"}, 32'(done), 0);
        @(negedge clk);
        check_eq({tag, ":err_off"}, 32'(err), 0);
        check_eq({tag, ":valid_off"}, 32'(valid), 0);
        check_eq({tag, ":busy_off"}, 32'(busy), 0);
        check_eq({tag, ":rdata_kept"}, rdata, e_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v_cnt, err_cyc, err_cnt, done_cnt;
        rst_n = 1'b0; req = 1'b0; wren = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        ready = 1'b0; mem_rdata = 32'h5555_5555; req_to = 1'b0; ready_to = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h80FF_0000;
        mem[8'h41] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        check_eq("rst:busy", 32'(busy), 0);
        check_eq("rst:done", 32'(done), 0);
        check_eq("rst:err", 32'(err), 0);
        check_eq("rst:valid", 32'(valid), 0);
        check_eq("rst:rdata", rdata, 0);
        check_eq("rst:bmask", 32'(bmask), 0);
        check_eq("rst:wdata", mem_wdata, 0);
        check_eq("rst:addr", 32'(mem_addr), 0);
        check_eq("rst:to_valid", 32'(valid_to), 0);
        rst_n = 1'b1;

        @(negedge clk); drive(1'b0, 3'd0, 32'h103, 32'h0);
        xfer("lb_103", 1'b1, 8, 4'b1000, 32'h0, 32'hFFFF_FF80); idle_chk("lb_103");

        mem[8'h40] = 32'h8001_1234;
        @(negedge clk); drive(1'b0, 3'd5, 32'h102, 32'h0);
        xfer("lhu_102", 1'b1, 2, 4'b1100, 32'h0, 32'h0000_8001); idle_chk("lhu_102");

        @(negedge clk); drive(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
        xfer("sw_100", 1'b1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0); idle_chk("sw_100");

        @(negedge clk); drive(1'b1, 3'd1, 32'h102, 32'h0000_ABCD);
        xfer("sh_102", 1'b1, 1, 4'b1100, 32'hABCD_ABCD, 32'h0); idle_chk("sh_102");

        @(negedge clk); drive(1'b0, 3'd2, 32'h100, 32'h0);
        xfer("lw_100", 1'b1, 3, 4'b1111, 32'h0, 32'hABCD_BEEF); idle_chk("lw_100");

        @(negedge clk); drive(1'b0, 3'd2, 32'h101, 32'h0); err_case("lw_mis", 32'hABCD_BEEF);
        @(negedge clk); drive(1'b0, 3'd3, 32'h100, 32'h0); err_case("ld_f3", 32'hABCD_BEEF);
        @(negedge clk); drive(1'b1, 3'd3, 32'h100, 32'h0); err_case("st_f3", 32'hABCD_BEEF);
        @(negedge clk); drive(1'b0, 3'd1, 32'h101, 32'h0); err_case("lh_mis", 32'hABCD_BEEF);

        @(negedge clk); drive(1'b0, 3'd4, 32'h101, 32'h0);
        xfer("lbu_101", 1'b1, 0, 4'b0010, 32'h0, 32'h0000_00BE); idle_chk("lbu_101");
        @(negedge clk); drive(1'b0, 3'd1, 32'h100, 32'h0);
        xfer("lh_100", 1'b1, 1, 4'b0011, 32'h0, 32'hFFFF_BEEF); idle_chk("lh_100");

        // Back-to-back with the request held high.
        @(negedge clk); drive(1'b1, 3'd0, 32'h105, 32'h1234_56A5);
        xfer("b2b_sb", 1'b0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        drive(1'b0, 3'd0, 32'h105, 32'h0);
        @(negedge clk);
        check_eq("b2b:gap_valid", 32'(valid), 0);
        check_eq("b2b:gap_busy", 32'(busy), 0);
        xfer("b2b_lb", 1'b1, 0, 4'b0010, 32'h0, 32'hFFFF_FFA5); idle_chk("b2b_lb");

        // Reset in the middle of an outstanding load.
        @(negedge clk); drive(1'b0, 3'd2, 32'h100, 32'h0);
        @(negedge clk); req = 1'b0;
        check_eq("rst_mid:valid_before", 32'(valid), 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_mid:valid", 32'(valid), 0);
        check_eq("rst_mid:busy", 32'(busy), 0);
        check_eq("rst_mid:done", 32'(done), 0);
        check_eq("rst_mid:err", 32'(err), 0);
        check_eq("rst_mid:rdata", rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid:done_after", 32'(done), 0);
        check_eq("rst_mid:err_after", 32'(err), 0);

        // Timeout on the short-timeout instance: READY never comes.
        v_cnt = 0; err_cyc = 0; err_cnt = 0; done_cnt = 0;
        @(negedge clk);
        wren = 1'b0; funct3 = 3'd2; addr = 32'h200; req_to = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            req_to = 1'b0;
            if (valid_to) v_cnt++;
            if (err_to) begin
                err_cnt++;
                if (err_cyc == 0) err_cyc = c;
            end
            if (done_to) done_cnt++;
        end
        check_eq("to:valid_cycles", 32'(v_cnt), 8);
        check_eq("to:err_cycle", 32'(err_cyc), 9);
        check_eq("to:err_pulses", 32'(err_cnt), 1);
        check_eq("to:done_pulses", 32'(done_cnt), 0);
        ready_to = 1'b1;
        @(negedge clk);
        ready_to = 1'b0;
        @(negedge clk);
        check_eq("to:stray_valid", 32'(valid_to), 0);
        check_eq("to:stray_done", 32'(done_to), 0);
        check_eq("to:stray_err", 32'(err_to), 0);
        check_eq("to:stray_busy", 32'(busy_to), 0);
        check_eq("to:rdata", rdata_to, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
